// File: rtl/dds_seq_pkg.sv
// Shared types and constants for the DDS generation sequencer (type codes, FSM states, error codes).
// Latency: none, constants and pure helper functions only.
// Backpressure: none.
package dds_seq_pkg;

  // Signal type codes; the value also indexes the per-accumulator flag vectors
  localparam logic [1:0] TYPE_TONE = 2'd0;
  localparam logic [1:0] TYPE_LFM  = 2'd1;
  localparam logic [1:0] TYPE_PSK  = 2'd2;
  localparam logic [1:0] TYPE_RSVD = 2'd3;

  // Sequencer FSM states
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CHECK    = 3'd1;
  localparam logic [2:0] ST_WAIT_RDY = 3'd2;
  localparam logic [2:0] ST_START    = 3'd3;
  localparam logic [2:0] ST_RUN      = 3'd4;
  localparam logic [2:0] ST_GAP      = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;
  localparam logic [2:0] ST_ERR      = 3'd7;

  // Error causes reported on ERR_CODE
  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_TYPE    = 3'd1;
  localparam logic [2:0] ERR_ZERO    = 3'd2;
  localparam logic [2:0] ERR_PERIOD  = 3'd3;
  localparam logic [2:0] ERR_FREQ    = 3'd4;
  localparam logic [2:0] ERR_ACK_TMO = 3'd5;
  localparam logic [2:0] ERR_ABORT   = 3'd6;
  localparam logic [2:0] ERR_WDOG    = 3'd7;

  // True for the three implemented accumulator types
  function automatic logic type_supported(input logic [1:0] t);
    case (t)
      TYPE_TONE, TYPE_LFM, TYPE_PSK: return 1'b1;
      TYPE_RSVD:                     return 1'b0;
      default:                       return 1'b0;
    endcase
  endfunction

  // Errors that leave an accumulator mid-operation and therefore need ACCUM_RESET
  function automatic logic err_resets_accum(input logic [2:0] code);
    return (code == ERR_ACK_TMO) || (code == ERR_ABORT) || (code == ERR_WDOG);
  endfunction

endpackage

// File: rtl/dds_seq_timer.sv
// Loadable down-counter with zero flag, shared by START timeout, GAP count and RUN watchdog.
// Latency: load visible next cycle; counts one per cycle and parks at zero.
// Backpressure: none.
module dds_seq_timer #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // Load has priority; otherwise decrement until zero is reached
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/dds_gen_sequencer.sv
// Command front-end for tone/LFM/PSK accumulators: validates a command, runs start/stop handshakes, repeats bursts with a gap.
// Latency: accept -> SIGN_START_GEN after 3 cycles with OUT_REG_READY high; DONE one cycle after the final stop flag.
// Backpressure: CMD_READY only in IDLE; WAIT_RDY stalls on OUT_REG_READY. Macro SEQ_WATCHDOG_EN adds a RUN watchdog (code 7).
module dds_gen_sequencer
  import dds_seq_pkg::*;
#(
  parameter int          ACK_TIMEOUT = 16,
  parameter logic [31:0] F_MAX       = 32'd4_200_000_000
`ifdef SEQ_WATCHDOG_EN
  ,
  parameter logic [31:0] WDOG_CYCLES = 32'hFFFF_FFFF
`endif
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [1:0]  CMD_TYPE,
  input  logic [31:0] CMD_F_CARRIER,
  input  logic [9:0]  CMD_T_IMPULSE,
  input  logic [12:0] CMD_T_PERIOD,
  input  logic [4:0]  CMD_NUM_OF_IMP,
  input  logic [7:0]  CMD_REPEAT,
  input  logic [15:0] CMD_GAP,
  input  logic        ABORT,
  input  logic        OUT_REG_READY,
  input  logic [2:0]  SIGN_START_CALC,
  input  logic [2:0]  SIGN_STOP_CALC,
  output logic [1:0]  SIGNAL_TYPE,
  output logic [31:0] F_CARRIER,
  output logic [9:0]  T_IMPULSE,
  output logic [12:0] T_PERIOD,
  output logic [4:0]  NUM_OF_IMP,
  output logic        SIGN_START_GEN,
  output logic        ACCUM_RESET,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic [2:0]  ERR_CODE
);

`ifdef SEQ_WATCHDOG_EN
  localparam int TMR_W = 32;
`else
  localparam int TMR_W = 16;
`endif

  logic [2:0]       state_q, state_d;
  logic [2:0]       err_d;
  logic             rdy_q;
  logic             accept;
  logic             in_op;
  logic [7:0]       repeat_q;
  logic [15:0]      gap_q;
  logic [7:0]       burst_q;
  logic [3:0]       start_ext, stop_ext;
  logic             start_flag, stop_flag;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_zero;

  // Pad flag vectors to 4 bits so the reserved type code has a (never set) slot
  assign start_ext  = {1'b0, SIGN_START_CALC};
  assign stop_ext   = {1'b0, SIGN_STOP_CALC};
  assign start_flag = start_ext[SIGNAL_TYPE];
  assign stop_flag  = stop_ext[SIGNAL_TYPE];

  // Abortable states; DONE and ERR already head back to IDLE on their own
  assign in_op  = (state_q == ST_CHECK) || (state_q == ST_WAIT_RDY) || (state_q == ST_START) ||
                  (state_q == ST_RUN)   || (state_q == ST_GAP);
  assign accept = CMD_VALID && CMD_READY && !ABORT;

  // FSM state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and error-cause selection; ABORT overrides every other transition
  always_comb begin
    state_d = state_q;
    err_d   = ERR_NONE;
    if (in_op && ABORT) begin
      state_d = ST_ERR;
      err_d   = ERR_ABORT;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) state_d = ST_CHECK;
        ST_CHECK: begin
          if (!type_supported(SIGNAL_TYPE))                            err_d = ERR_TYPE;
          else if (T_IMPULSE == '0 || NUM_OF_IMP == '0)                err_d = ERR_ZERO;
          else if (NUM_OF_IMP > 5'd1 && T_PERIOD < {3'b000, T_IMPULSE}) err_d = ERR_PERIOD;
          else if (F_CARRIER > F_MAX)                                   err_d = ERR_FREQ;
          state_d = (err_d == ERR_NONE) ? ST_WAIT_RDY : ST_ERR;
        end
        ST_WAIT_RDY: if (OUT_REG_READY) state_d = ST_START;
        ST_START: begin
          if (start_flag) begin
            state_d = ST_RUN;
          end else if (tmr_zero) begin
            state_d = ST_ERR;
            err_d   = ERR_ACK_TMO;
          end
        end
        ST_RUN: begin
          if (stop_flag) begin
            if (burst_q == repeat_q) state_d = ST_DONE;
            else if (gap_q == '0)    state_d = ST_WAIT_RDY;
            else                     state_d = ST_GAP;
          end
`ifdef SEQ_WATCHDOG_EN
          else if (tmr_zero) begin
            state_d = ST_ERR;
            err_d   = ERR_WDOG;
          end
`endif
        end
        ST_GAP:  if (tmr_zero) state_d = ST_WAIT_RDY;
        ST_DONE: state_d = ST_IDLE;
        ST_ERR:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the current state
  always_comb begin
    CMD_READY      = rdy_q && (state_q == ST_IDLE);
    SIGN_START_GEN = (state_q == ST_START);
    BUSY           = in_op;
    DONE           = (state_q == ST_DONE);
    ACCUM_RESET    = (state_q == ST_ERR) && err_resets_accum(ERR_CODE);
  end

  // Timer reloads on every state change with the budget of the state being entered
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_val  = '0;
    case (state_d)
      ST_START: tmr_val = TMR_W'(ACK_TIMEOUT - 1);
      ST_GAP:   tmr_val = TMR_W'(gap_q - 16'd1);
`ifdef SEQ_WATCHDOG_EN
      ST_RUN:   tmr_val = TMR_W'(WDOG_CYCLES - 32'd1);
`endif
      default:  tmr_val = '0;
    endcase
  end

  dds_seq_timer #(.W(TMR_W)) u_timer (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // CMD_READY is held off until the first clock after reset release
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) rdy_q <= 1'b0;
    else       rdy_q <= 1'b1;
  end

  // Command fields are captured on accept and stay frozen until the next accept
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      SIGNAL_TYPE <= '0;
      F_CARRIER   <= '0;
      T_IMPULSE   <= '0;
      T_PERIOD    <= '0;
      NUM_OF_IMP  <= '0;
      repeat_q    <= '0;
      gap_q       <= '0;
    end else if (accept) begin
      SIGNAL_TYPE <= CMD_TYPE;
      F_CARRIER   <= CMD_F_CARRIER;
      T_IMPULSE   <= CMD_T_IMPULSE;
      T_PERIOD    <= CMD_T_PERIOD;
      NUM_OF_IMP  <= CMD_NUM_OF_IMP;
      repeat_q    <= CMD_REPEAT;
      gap_q       <= CMD_GAP;
    end
  end

  // Burst counter: cleared on accept, advanced when a non-final burst completes
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      burst_q <= '0;
    end else if (accept) begin
      burst_q <= '0;
    end else if (state_q == ST_RUN && (state_d == ST_GAP || state_d == ST_WAIT_RDY)) begin
      burst_q <= burst_q + 8'd1;
    end
  end

  // Sticky error flag and cause; cleared only by a new accepted command
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ERROR    <= 1'b0;
      ERR_CODE <= ERR_NONE;
    end else if (accept) begin
      ERROR    <= 1'b0;
      ERR_CODE <= ERR_NONE;
    end else if (state_d == ST_ERR && state_q != ST_ERR) begin
      ERROR    <= 1'b1;
      ERR_CODE <= err_d;
    end
  end

endmodule

// File: tb/tb_dds_gen_sequencer.sv
// Directed bench for dds_gen_sequencer: nominal LFM/PSK runs, check errors, timeouts, abort and async reset.
// Latency: stimulus driven 1 time unit after each rising edge; outputs sampled at the same point.
// Backpressure: OUT_REG_READY and accumulator flags driven directly by the step sequence.
module tb_dds_gen_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [1:0]  CMD_TYPE = '0;
  logic [31:0] CMD_F_CARRIER = '0;
  logic [9:0]  CMD_T_IMPULSE = '0;
  logic [12:0] CMD_T_PERIOD = '0;
  logic [4:0]  CMD_NUM_OF_IMP = '0;
  logic [7:0]  CMD_REPEAT = '0;
  logic [15:0] CMD_GAP = '0;
  logic        ABORT = 1'b0;
  logic        OUT_REG_READY = 1'b0;
  logic [2:0]  SIGN_START_CALC = '0;
  logic [2:0]  SIGN_STOP_CALC = '0;
  logic [1:0]  SIGNAL_TYPE;
  logic [31:0] F_CARRIER;
  logic [9:0]  T_IMPULSE;
  logic [12:0] T_PERIOD;
  logic [4:0]  NUM_OF_IMP;
  logic        SIGN_START_GEN, ACCUM_RESET, BUSY, DONE, ERROR;
  logic [2:0]  ERR_CODE;

  int passes = 0;
  int total = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int gen_rises = 0;
  int done_cnt = 0;
  logic gen_prev = 1'b0;

  dds_gen_sequencer dut (
    .CLK(CLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_TYPE(CMD_TYPE), .CMD_F_CARRIER(CMD_F_CARRIER), .CMD_T_IMPULSE(CMD_T_IMPULSE),
    .CMD_T_PERIOD(CMD_T_PERIOD), .CMD_NUM_OF_IMP(CMD_NUM_OF_IMP), .CMD_REPEAT(CMD_REPEAT),
    .CMD_GAP(CMD_GAP), .ABORT(ABORT), .OUT_REG_READY(OUT_REG_READY),
    .SIGN_START_CALC(SIGN_START_CALC), .SIGN_STOP_CALC(SIGN_STOP_CALC),
    .SIGNAL_TYPE(SIGNAL_TYPE), .F_CARRIER(F_CARRIER), .T_IMPULSE(T_IMPULSE),
    .T_PERIOD(T_PERIOD), .NUM_OF_IMP(NUM_OF_IMP), .SIGN_START_GEN(SIGN_START_GEN),
    .ACCUM_RESET(ACCUM_RESET), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .ERR_CODE(ERR_CODE)
  );

  always #5 CLK = ~CLK;

  // Count GEN rising edges and DONE cycles on the falling edge
  always @(negedge CLK) begin
    if (SIGN_START_GEN && !gen_prev) gen_rises++;
    gen_prev = SIGN_START_GEN;
    if (DONE) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
  endtask

  task automatic send_cmd(input logic [1:0] t, input logic [31:0] f, input logic [9:0] ti,
                          input logic [12:0] tp, input logic [4:0] ni, input logic [7:0] rp,
                          input logic [15:0] gp);
    CMD_TYPE = t; CMD_F_CARRIER = f; CMD_T_IMPULSE = ti; CMD_T_PERIOD = tp;
    CMD_NUM_OF_IMP = ni; CMD_REPEAT = rp; CMD_GAP = gp;
    CMD_VALID = 1'b1;
    step();
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_gen(input string tag, input int lim);
    int n = 0;
    while (SIGN_START_GEN !== 1'b1 && n < lim) begin
      step();
      n++;
    end
    chk(tag, 32'(SIGN_START_GEN), 32'd1);
  endtask

  task automatic err_case(input string tag, input logic [1:0] t, input logic [31:0] f,
                          input logic [9:0] ti, input logic [12:0] tp, input logic [4:0] ni,
                          input logic [2:0] code);
    int g0 = gen_rises;
    send_cmd(t, f, ti, tp, ni, 8'd0, 16'd0);
    step();
    chk({tag, "_code"}, 32'(ERR_CODE), 32'(code));
    chk({tag, "_error"}, 32'(ERROR), 32'd1);
    chk({tag, "_busy"}, 32'(BUSY), 32'd0);
    chk({tag, "_accrst"}, 32'(ACCUM_RESET), 32'd0);
    step();
    chk({tag, "_ready"}, 32'(CMD_READY), 32'd1);
    chk({tag, "_nogen"}, 32'(gen_rises - g0), 32'd0);
  endtask

  task automatic timeout_case(input string tag, input logic [2:0] calc);
    OUT_REG_READY = 1'b0;
    send_cmd(2'd0, 32'd1000, 10'd10, 13'd20, 5'd1, 8'd0, 16'd0);
    step();
    repeat (3) step();
    chk({tag, "_wait_gen"}, 32'(SIGN_START_GEN), 32'd0);
    chk({tag, "_wait_busy"}, 32'(BUSY), 32'd1);
    OUT_REG_READY = 1'b1;
    step();
    SIGN_START_CALC = calc;
    chk({tag, "_gen_on"}, 32'(SIGN_START_GEN), 32'd1);
    repeat (15) step();
    chk({tag, "_gen_last"}, 32'(SIGN_START_GEN), 32'd1);
    step();
    chk({tag, "_code"}, 32'(ERR_CODE), 32'd5);
    chk({tag, "_accrst"}, 32'(ACCUM_RESET), 32'd1);
    chk({tag, "_gen_off"}, 32'(SIGN_START_GEN), 32'd0);
    SIGN_START_CALC = 3'b000;
    step();
    chk({tag, "_accrst_end"}, 32'(ACCUM_RESET), 32'd0);
    chk({tag, "_ready"}, 32'(CMD_READY), 32'd1);
  endtask

  initial begin
    int g0, d0;
    // Reset state
    #3;
    chk("rst_ready", 32'(CMD_READY), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_gen", 32'(SIGN_START_GEN), 32'd0);
    chk("rst_err", 32'({ERROR, ERR_CODE}), 32'd0);
    chk("rst_fc", F_CARRIER, 32'd0);
    step();
    RESET = 1'b0;
    step();
    chk("ready_after_rst", 32'(CMD_READY), 32'd1);
    OUT_REG_READY = 1'b1;

    // LFM single burst, carrier exactly at F_MAX, start flag 2 cycles after GEN
    g0 = gen_rises; d0 = done_cnt;
    send_cmd(2'd1, 32'd4_200_000_000, 10'd10, 13'd100, 5'd3, 8'd0, 16'd0);
    chk("lfm_ready_drop", 32'(CMD_READY), 32'd0);
    chk("lfm_busy", 32'(BUSY), 32'd1);
    chk("lfm_type", 32'(SIGNAL_TYPE), 32'd1);
    chk("lfm_fc", F_CARRIER, 32'd4_200_000_000);
    chk("lfm_nimp", 32'(NUM_OF_IMP), 32'd3);
    wait_gen("lfm_gen", 10);
    step();
    SIGN_START_CALC = 3'b010;
    step();
    SIGN_START_CALC = 3'b000;
    chk("lfm_gen_drop", 32'(SIGN_START_GEN), 32'd0);
    chk("lfm_run_busy", 32'(BUSY), 32'd1);
    repeat (3) step();
    SIGN_STOP_CALC = 3'b010;
    step();
    SIGN_STOP_CALC = 3'b000;
    chk("lfm_done", 32'(DONE), 32'd1);
    chk("lfm_done_busy", 32'(BUSY), 32'd0);
    chk("lfm_error", 32'(ERROR), 32'd0);
    CMD_F_CARRIER = 32'd7;
    step();
    chk("lfm_done_pulse", 32'(DONE), 32'd0);
    chk("lfm_gen_count", 32'(gen_rises - g0), 32'd1);
    chk("lfm_done_count", 32'(done_cnt - d0), 32'd1);
    chk("lfm_params_frozen", F_CARRIER, 32'd4_200_000_000);

    // PSK, three bursts with a 10-cycle gap; T_PERIOD<T_IMPULSE is legal for one impulse
    g0 = gen_rises; d0 = done_cnt;
    send_cmd(2'd2, 32'd50_000_000, 10'd10, 13'd5, 5'd1, 8'd2, 16'd10);
    for (int b = 0; b < 3; b++) begin
      wait_gen("psk_gen", 40);
      if (b > 0) chk("psk_gap_cycles", 32'(cyc - stop_cyc), 32'd11);
      SIGN_START_CALC = 3'b100;
      step();
      SIGN_START_CALC = 3'b000;
      chk("psk_gen_drop", 32'(SIGN_START_GEN), 32'd0);
      repeat (3) step();
      SIGN_STOP_CALC = 3'b100;
      step();
      SIGN_STOP_CALC = 3'b000;
      stop_cyc = cyc;
      chk("psk_done", 32'(DONE), (b == 2) ? 32'd1 : 32'd0);
    end
    step();
    chk("psk_gen_count", 32'(gen_rises - g0), 32'd3);
    chk("psk_done_count", 32'(done_cnt - d0), 32'd1);
    chk("psk_error", 32'(ERROR), 32'd0);

    // Range-check failures, including priority of type over zero-length
    err_case("type_rsvd", 2'd3, 32'd1000, 10'd10, 13'd100, 5'd1, 3'd1);
    err_case("type_over_zero", 2'd3, 32'd1000, 10'd0, 13'd100, 5'd0, 3'd1);
    err_case("zero_nimp", 2'd0, 32'd1000, 10'd10, 13'd100, 5'd0, 3'd2);
    err_case("period_short", 2'd1, 32'd1000, 10'd60, 13'd5, 5'd2, 3'd3);
    err_case("freq_high", 2'd0, 32'd4_200_000_001, 10'd10, 13'd100, 5'd1, 3'd4);

    // START acknowledge timeout, with no flag and with flags on other indices
    timeout_case("tmo_none", 3'b000);
    timeout_case("tmo_wrong_idx", 3'b110);

    // ABORT during RUN
    send_cmd(2'd1, 32'd1000, 10'd10, 13'd100, 5'd1, 8'd0, 16'd0);
    chk("abort_accept_clr", 32'({ERROR, ERR_CODE}), 32'd0);
    wait_gen("abort_gen", 10);
    SIGN_START_CALC = 3'b010;
    step();
    SIGN_START_CALC = 3'b000;
    repeat (2) step();
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    chk("abort_accrst", 32'(ACCUM_RESET), 32'd1);
    chk("abort_code", 32'(ERR_CODE), 32'd6);
    chk("abort_error", 32'(ERROR), 32'd1);
    chk("abort_busy", 32'(BUSY), 32'd0);
    step();
    chk("abort_accrst_end", 32'(ACCUM_RESET), 32'd0);
    chk("abort_ready", 32'(CMD_READY), 32'd1);

    // ABORT together with CMD_VALID in IDLE: nothing accepted, error state untouched
    ABORT = 1'b1;
    CMD_VALID = 1'b1;
    step();
    CMD_VALID = 1'b0;
    ABORT = 1'b0;
    chk("idle_abort_busy", 32'(BUSY), 32'd0);
    chk("idle_abort_ready", 32'(CMD_READY), 32'd1);
    chk("idle_abort_code", 32'(ERR_CODE), 32'd6);
    step();
    chk("idle_abort_busy2", 32'(BUSY), 32'd0);

    // Asynchronous reset in the middle of RUN
    send_cmd(2'd1, 32'd1234, 10'd10, 13'd100, 5'd1, 8'd0, 16'd0);
    wait_gen("arst_gen", 10);
    SIGN_START_CALC = 3'b010;
    step();
    SIGN_START_CALC = 3'b000;
    step();
    chk("arst_pre_busy", 32'(BUSY), 32'd1);
    #2;
    RESET = 1'b1;
    #1;
    chk("arst_busy", 32'(BUSY), 32'd0);
    chk("arst_fc", F_CARRIER, 32'd0);
    chk("arst_type", 32'(SIGNAL_TYPE), 32'd0);
    chk("arst_ready", 32'(CMD_READY), 32'd0);
    step();
    RESET = 1'b0;
    step();
    chk("arst_ready_after", 32'(CMD_READY), 32'd1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
